// File: rtl/axi4_burst_seq.sv
// AXI4 burst sequencer: accepts one AW/AR-style burst request and issues its
// beat addresses one per cycle, chaining the next request without a bubble.
`ifndef AXI4_ADDR_OFT_WIDTH
`define AXI4_ADDR_OFT_WIDTH 32
`endif

module axi4_burst_seq #(
    parameter int ID_WIDTH = 4
) (
    input  logic                            clk_i,
    input  logic                            rst_n_i,
    input  logic                            req_valid_i,
    output logic                            req_ready_o,
    input  logic [ID_WIDTH-1:0]             req_id_i,
    input  logic [`AXI4_ADDR_OFT_WIDTH-1:0] req_addr_i,
    input  logic [7:0]                      req_len_i,
    input  logic [2:0]                      req_size_i,
    input  logic [1:0]                      req_burst_i,
    output logic                            beat_valid_o,
    input  logic                            beat_ready_i,
    output logic [`AXI4_ADDR_OFT_WIDTH-1:0] beat_addr_o,
    output logic [ID_WIDTH-1:0]             beat_id_o,
    output logic                            beat_last_o,
    output logic                            beat_err_o,
    output logic                            busy_o
);
    localparam int AW = `AXI4_ADDR_OFT_WIDTH;

    localparam logic [1:0] BURST_INCR = 2'b01;
    localparam logic [1:0] BURST_WRAP = 2'b10;

    typedef enum logic {IDLE, BURST} state_t;

    state_t                state;
    logic [7:0]            beat_cnt;
    logic [7:0]            len_q;
    logic [2:0]            size_q;
    logic [1:0]            burst_q;
    logic [AW-1:0]         addr_q;
    logic [ID_WIDTH-1:0]   id_q;
    logic                  last_q;
    logic                  err_q;

    logic                  req_hs;
    logic                  beat_hs;
    logic [AW-1:0]         shifted;
    logic [7:0]            wrap_low;
    logic [AW-1:0]         next_addr;

    // A new request is also accepted during the final beat handshake so bursts chain back to back.
    assign req_ready_o  = (state == IDLE) || (last_q && beat_ready_i);
    assign req_hs       = req_valid_i && req_ready_o;
    assign beat_hs      = (state == BURST) && beat_ready_i;

    assign beat_valid_o = (state == BURST);
    assign busy_o       = (state == BURST);
    assign beat_addr_o  = addr_q;
    assign beat_id_o    = id_q;
    assign beat_last_o  = last_q;
    assign beat_err_o   = err_q;

    // Next beat address works in units of the transfer size; error bursts hold the start address.
    always_comb begin
        shifted   = addr_q >> size_q;
        wrap_low  = (shifted[7:0] & ~len_q) | ((shifted[7:0] + 8'd1) & len_q);
        next_addr = addr_q;
        if (!err_q) begin
            case (burst_q)
                BURST_INCR: next_addr = (shifted + {{(AW-1){1'b0}}, 1'b1}) << size_q;
                BURST_WRAP: next_addr = {shifted[AW-1:8], wrap_low} << size_q;
                default:    next_addr = addr_q;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state    <= IDLE;
            beat_cnt <= 8'd0;
            len_q    <= 8'd0;
            size_q   <= 3'd0;
            burst_q  <= 2'd0;
            addr_q   <= '0;
            id_q     <= '0;
            last_q   <= 1'b0;
            err_q    <= 1'b0;
        end else if (req_hs) begin
            state    <= BURST;
            beat_cnt <= 8'd0;
            len_q    <= req_len_i;
            size_q   <= req_size_i;
            burst_q  <= req_burst_i;
            addr_q   <= req_addr_i;
            id_q     <= req_id_i;
            last_q   <= (req_len_i == 8'd0);
            err_q    <= (req_size_i > 3'd3) || (req_burst_i == 2'b11);
        end else if (beat_hs) begin
            if (last_q) begin
                state  <= IDLE;
                last_q <= 1'b0;
                err_q  <= 1'b0;
            end else begin
                beat_cnt <= beat_cnt + 8'd1;
                addr_q   <= next_addr;
                last_q   <= ((beat_cnt + 8'd1) == len_q);
            end
        end
    end

endmodule

// File: doc/axi4_burst_seq.md
AXI4_BURST_SEQ -- requirements
Module: axi4_burst_seq

Interface
REQ-001 SHALL have parameter: ID_WIDTH, default 4, width of the transaction ID carried from request to beats.
REQ-002 SHALL use address width `AXI4_ADDR_OFT_WIDTH (AW below) from axi4_define.svh for all address ports.
REQ-003 SHALL have ports, one per line: name, direction, width, meaning.
- clk_i  in  1  single clock; all state updates on the rising edge.
- rst_n_i  in  1  asynchronous, active-low reset.
- req_valid_i  in  1  AW/AR-style burst request valid.
- req_ready_o  out  1  request accepted when valid and ready are both high.
- req_id_i  in  ID_WIDTH  request ID.
- req_addr_i  in  AW  start address.
- req_len_i  in  8  AxLEN; beats = len+1.
- req_size_i  in  3  AxSIZE.
- req_burst_i  in  2  AxBURST (FIXED/INCR/WRAP).
- beat_valid_o  out  1  per-beat address valid.
- beat_ready_i  in  1  downstream accepts the beat.
- beat_addr_o  out  AW  address of the current beat.
- beat_id_o  out  ID_WIDTH  ID of the burst in progress.
- beat_last_o  out  1  current beat is the final beat of the burst.
- beat_err_o  out  1  burst has unsupported size (>8 bytes) or reserved burst type.
- busy_o  out  1  a burst is in progress.

Function
REQ-004 SHALL implement two states: IDLE and BURST.
REQ-005 In IDLE, req_ready_o SHALL be 1 and beat_valid_o SHALL be 0.
REQ-006 On a request handshake, SHALL capture id, addr, len, size and burst, clear the beat counter to 0, and enter BURST on the next cycle.
REQ-007 In BURST, beat_valid_o SHALL be 1 and SHALL be held, with all beat_* outputs stable, until beat_ready_i is high.
REQ-008 First beat address SHALL equal req_addr_i unmodified, including when unaligned.
REQ-009 On each beat handshake that is not the last, SHALL increment the beat counter and load the next address using AXI4 rules.
- FIXED: address unchanged.
- INCR: next = ((addr >> size) + 1) << size, so the second beat is aligned.
- WRAP: the low 8 bits of the shifted address wrap under mask len; bits above 8 pass through; result is shifted back left by size.
- All arithmetic is modulo 2^AW; carry out of bit AW-1 is discarded.
REQ-010 Next-address computation SHALL be bit-identical to the team's axi4_addr_gen block, either by instantiating it or by an equivalent.
REQ-011 beat_last_o SHALL be 1 exactly when beat counter == captured len; len=0 gives a single beat with last=1.
REQ-012 On the last-beat handshake, req_ready_o SHALL be 1 in that same cycle.
- If req_valid_i is also high, the new request SHALL be captured and BURST continues with no bubble.
- Otherwise, SHALL return to IDLE.
REQ-013 Outside the REQ-012 case, req_ready_o SHALL be 0 while in BURST.
REQ-014 beat_err_o SHALL be 1 for the whole burst if captured size > 3 or burst == 2'b11.
- Such bursts still issue len+1 beats.
- Address is held at the start address for every beat.
REQ-015 busy_o SHALL be 1 in BURST, 0 in IDLE.
REQ-016 All outputs SHALL be registered or derived only from state registers; there is no combinational path from req_* to beat_*.
REQ-017 Beat throughput SHALL be one beat per cycle while beat_ready_i is held high.

Reset
REQ-018 Asserting rst_n_i low SHALL at once force IDLE, and clear the beat counter and all captured fields to 0.
REQ-019 After reset, outputs SHALL be: req_ready_o=1, beat_valid_o=0, beat_last_o=0, beat_err_o=0, busy_o=0, beat_addr_o=0, beat_id_o=0.
REQ-020 Reset asserted mid-burst SHALL abort the burst; no further beats of it are issued after reset is released.

Verification
REQ-021 INCR: addr=0x1002, size=2, len=3, ready always high -> beats 0x1002, 0x1004, 0x1008, 0x100C; last only on the 4th beat.
REQ-022 WRAP: addr=0x0038, size=3, len=3 -> beats 0x38, 0x20, 0x28, 0x30; last on 0x30.
REQ-023 FIXED: addr=0x0100, len=2, with beat_ready_i low for 3 cycles on beat 1 -> three beats all at 0x100; outputs stable while stalled.
REQ-024 Back-to-back: second request valid during the last-beat handshake of burst A -> its first beat appears the next cycle; busy_o never drops.
REQ-025 Error: size=4, len=1 -> 2 beats at the start address, beat_err_o=1 on both; rst_n_i pulsed low mid-burst -> reset values per REQ-019 and no further beats.
